spi_word_assembler: RTL
=======================

SPI_WORD_ASSEMBLER -- requirements
Module: spi_word_assembler

Interface
REQ-001 Parameter BYTES, default 4, sets the number of bytes per assembled word; legal range 1..16.
REQ-002 Parameter MSB_FIRST, default 1, selects byte order: 1 places the first byte in the top byte of the word; 0 places the first byte in the bottom byte.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port done_rx, input, 1 bit: one-cycle strobe from the SPI peripheral meaning a byte has been received.
REQ-006 Port apply, input, 1 bit: qualifier for done_rx; a byte is accepted only when done_rx and apply are both 1.
REQ-007 Port recieved_byte, input, 8 bits: byte data, sampled on the accept cycle.
REQ-008 Port flush, input, 1 bit: discards the partial word in progress.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts out this cycle when out_valid is 1.
REQ-010 Port clear_overflow, input, 1 bit: clears the overflow flag.
REQ-011 Port out, output, 8*BYTES bits: the assembled word, registered.
REQ-012 Port out_valid, output, 1 bit: out holds a word not yet taken by the consumer.
REQ-013 Port byte_count, output, $clog2(BYTES+1) bits: number of bytes held in the partial word.
REQ-014 Port busy, output, 1 bit: 1 when byte_count is non-zero.
REQ-015 Port overflow, output, 1 bit: sticky flag, set when a completed word was dropped.

Function
REQ-016 Accept event: done_rx & apply at a rising clk edge.
- done_rx without apply: ignored.
- apply without done_rx: ignored.
REQ-017 Each accept stores recieved_byte in the shift register and increments byte_count.
- MSB_FIRST=1: shift left by 8 and insert the byte at bits [7:0].
- MSB_FIRST=0: write the byte into lane byte_count, bits [8*k+7:8*k].
REQ-018 Completion: an accept while byte_count == BYTES-1. On that edge:
- the full word, including the current byte, is computed;
- byte_count returns to 0;
- the shift register is cleared.
REQ-019 On completion, the word is loaded into out on the same edge if the output buffer is free. out_valid is then 1 in the next cycle (latency 1 clk from the last accept).
REQ-020 The output buffer is free when out_valid == 0, or when out_valid == 1 and out_ready == 1 in that cycle.
REQ-021 Completion with out_valid == 1 and out_ready == 0:
- the new word is dropped;
- out is unchanged;
- overflow is set to 1.
REQ-022 Handshake without completion: out_valid == 1 and out_ready == 1 clears out_valid on that edge.
REQ-023 Handshake with completion in the same cycle: out loads the new word and out_valid stays 1.
REQ-024 out and out_valid hold their values while out_ready == 0.
REQ-025 Output FSM has two states:
- EMPTY to FULL on completion;
- FULL to EMPTY on handshake with no completion;
- FULL to FULL on handshake with completion, or on completion with overflow.
REQ-026 flush == 1 clears byte_count and the shift register on that edge.
- flush has priority over a simultaneous accept; that byte is discarded.
- flush does not affect out, out_valid or overflow.
REQ-027 overflow clears only on clear_overflow or reset. If set and clear occur in the same cycle, set wins.
REQ-028 BYTES == 1: every accept is a completion.
REQ-029 busy == (byte_count != 0), combinational.

Reset
REQ-030 While rst == 0, asynchronously and regardless of clk:
- byte_count = 0 and the shift register = 0;
- out = 0 and out_valid = 0;
- overflow = 0.
REQ-031 Reset mid-word discards the partial word. Reset while out_valid == 1 discards the held word.
REQ-032 Reset deassertion is synchronous to clk. The first accept is honoured on the first rising edge with rst == 1.

Verification
REQ-033 BYTES=4, MSB_FIRST=1, out_ready=1; accept 0x11,0x22,0x33,0x44 -> out = 0x11223344, out_valid high exactly 1 cycle, starting the edge after the 4th accept.
REQ-034 BYTES=4, MSB_FIRST=0; same bytes -> out = 0x44332211.
REQ-035 out_ready=0; send 8 bytes -> first word held in out, overflow=1, byte_count=0. Then pulse clear_overflow -> overflow=0.
REQ-036 Send 2 bytes, then flush together with a 3rd accept; then send 0xA0,0xB1,0xC2,0xD3 -> out = 0xA0B1C2D3, overflow=0.
REQ-037 Hold done_rx=1 with apply=0 for 10 cycles -> byte_count stays 0. Assert rst low after 3 accepts -> all outputs 0 immediately, without waiting for a clk edge.
REQ-038 BYTES=2, with out_valid=1 and out_ready=1 in the completion cycle -> new word in out, out_valid stays 1, overflow=0.

Source files
------------

// File: rtl/spi_word_assembler_if.sv
// spi_word_assembler_if: byte-in / word-out handshake bundle for spi_word_assembler
interface spi_word_assembler_if #(parameter int BYTES = 4);
  logic done_rx;
  logic apply;
  logic [7:0] recieved_byte;
  logic flush;
  logic out_ready;
  logic clear_overflow;
  logic [8*BYTES-1:0] out;
  logic out_valid;
  logic [$clog2(BYTES+1)-1:0] byte_count;
  logic busy;
  logic overflow;
  modport master(
    output done_rx, apply, recieved_byte, flush, out_ready, clear_overflow,
    input out, out_valid, byte_count, busy, overflow
  );
  modport slave(
    input done_rx, apply, recieved_byte, flush, out_ready, clear_overflow,
    output out, out_valid, byte_count, busy, overflow
  );
endinterface

// File: rtl/spi_word_assembler.sv
// spi_word_assembler: packs accepted SPI bytes into BYTES-wide words behind a one-entry output buffer
module spi_word_assembler #(
  parameter int BYTES = 4,
  parameter bit MSB_FIRST = 1
) (
  input logic clk,
  input logic rst,
  spi_word_assembler_if.slave bus
);
  localparam int W = 8*BYTES;
  localparam int CW = $clog2(BYTES+1);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [W-1:0] sh, word;
  logic [CW-1:0] cnt;
  logic acc, done, free;
  // flush wins over a same-cycle accept, so it also suppresses completion
  always_comb begin
    acc = bus.done_rx & bus.apply & ~bus.flush;
    done = acc & (cnt == CW'(BYTES-1));
    free = (state == EMPTY) | bus.out_ready;
    word = MSB_FIRST ? (sh << 8) | W'(bus.recieved_byte)
                     : sh | (W'(bus.recieved_byte) << (8*cnt));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sh <= '0;
      cnt <= '0;
      state <= EMPTY;
      bus.out <= '0;
      bus.overflow <= 1'b0;
    end else begin
      if (bus.flush || done) begin
        sh <= '0;
        cnt <= '0;
      end else if (acc) begin
        sh <= word;
        cnt <= cnt + 1'b1;
      end
      if (done && free) begin
        bus.out <= word;
        state <= FULL;
      end else if (bus.out_ready) state <= EMPTY;
      if (done && !free) bus.overflow <= 1'b1;
      else if (bus.clear_overflow) bus.overflow <= 1'b0;
    end
  assign bus.out_valid = state == FULL;
  assign bus.byte_count = cnt;
  assign bus.busy = cnt != '0;
endmodule
